// File: rtl/axi4_wr_rr_arbiter.sv
// Round-robin arbiter sharing one downstream AXI4 write port between NUM
// upstream masters. One whole transaction (AW, all W beats, B) is in flight
// at a time; the outgoing AWID carries the owner index so B can be routed
// back, and a sticky flag records any W beat count that disagrees with AWLEN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate among s_awvalid from rr_ptr+1 upward
// AW      | owner g drives the downstream AW channel
// W       | owner g drives W beats; beats counted against exp_len
// B       | downstream B response routed back to owner g

module axi4_wr_rr_arbiter #(
  parameter int NUM    = 4,
  parameter int IDSIZE = 4,
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 8,
  parameter int DSIZE  = 32
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,

  input  logic [NUM-1:0]        s_awvalid,
  output logic [NUM-1:0]        s_awready,
  input  logic [NUM*ASIZE-1:0]  s_awaddr,
  input  logic [NUM*LSIZE-1:0]  s_awlen,
  input  logic [NUM*IDSIZE-1:0] s_awid,
  input  logic [NUM-1:0]        s_wvalid,
  output logic [NUM-1:0]        s_wready,
  input  logic [NUM-1:0]        s_wlast,
  input  logic [NUM*DSIZE-1:0]  s_wdata,
  output logic [NUM-1:0]        s_bvalid,
  input  logic [NUM-1:0]        s_bready,
  output logic [IDSIZE-1:0]     s_bid,
  output logic [1:0]            s_bresp,

  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ASIZE-1:0]      m_awaddr,
  output logic [LSIZE-1:0]      m_awlen,
  output logic [IDSIZE+2:0]     m_awid,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic                  m_wlast,
  output logic [DSIZE-1:0]      m_wdata,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [IDSIZE+2:0]     m_bid,
  input  logic [1:0]            m_bresp,

  output logic [NUM-1:0]        grant,
  output logic                  err_len
);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  state_t           state_q, state_d;
  logic [2:0]       g_q, g_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM-1:0]   grant_q, grant_d;
  logic [LSIZE-1:0] exp_len_q, exp_len_d;
  logic [LSIZE:0]   beat_cnt_q, beat_cnt_d;
  logic             err_len_q, err_len_d;

  logic              sel_awvalid;
  logic [ASIZE-1:0]  sel_awaddr;
  logic [LSIZE-1:0]  sel_awlen;
  logic [IDSIZE-1:0] sel_awid;
  logic              sel_wvalid;
  logic              sel_wlast;
  logic [DSIZE-1:0]  sel_wdata;
  logic              sel_bready;

  logic              req_found;
  logic [2:0]        pick_idx;
  logic [NUM-1:0]    pick_oh;
  int                arb_cand;

  logic [LSIZE:0]    beat_inc;
  logic [LSIZE+1:0]  beats_seen;
  logic [LSIZE+1:0]  beats_expected;

  // Upper m_bid bits carry our own grant index; only the upstream id is returned.
  logic unused_bid_hi;
  assign unused_bid_hi = ^m_bid[IDSIZE+2:IDSIZE];

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q    <= ST_IDLE;
      g_q        <= '0;
      rr_ptr_q   <= 3'(NUM-1);
      grant_q    <= '0;
      exp_len_q  <= '0;
      beat_cnt_q <= '0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      exp_len_q  <= exp_len_d;
      beat_cnt_q <= beat_cnt_d;
      err_len_q  <= err_len_d;
    end
  end

  // Requester-side mux selected by the registered one-hot grant (all zero in IDLE).
  always_comb begin
    sel_awvalid = 1'b0;
    sel_awaddr  = '0;
    sel_awlen   = '0;
    sel_awid    = '0;
    sel_wvalid  = 1'b0;
    sel_wlast   = 1'b0;
    sel_wdata   = '0;
    sel_bready  = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (grant_q[i]) begin
        sel_awvalid = s_awvalid[i];
        sel_awaddr  = s_awaddr[i*ASIZE +: ASIZE];
        sel_awlen   = s_awlen[i*LSIZE +: LSIZE];
        sel_awid    = s_awid[i*IDSIZE +: IDSIZE];
        sel_wvalid  = s_wvalid[i];
        sel_wlast   = s_wlast[i];
        sel_wdata   = s_wdata[i*DSIZE +: DSIZE];
        sel_bready  = s_bready[i];
      end
    end
  end

  // Rotating priority search: first requester at or after rr_ptr+1, wrapping mod NUM.
  always_comb begin
    req_found = 1'b0;
    pick_idx  = '0;
    pick_oh   = '0;
    arb_cand  = 0;
    for (int k = 1; k <= NUM; k++) begin
      arb_cand = int'(rr_ptr_q) + k;
      if (arb_cand >= NUM) arb_cand = arb_cand - NUM;
      for (int j = 0; j < NUM; j++) begin
        if (!req_found && (j == arb_cand) && s_awvalid[j]) begin
          req_found  = 1'b1;
          pick_idx   = 3'(j);
          pick_oh[j] = 1'b1;
        end
      end
    end
  end

  // Next-state and datapath updates for the transaction sequence.
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    exp_len_d  = exp_len_q;
    beat_cnt_d = beat_cnt_q;
    err_len_d  = err_len_q;

    beat_inc       = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 1'b1;
    // Compared one bit wider so a saturated counter can never alias a legal length.
    beats_seen     = {1'b0, beat_cnt_q} + (LSIZE+2)'(1);
    beats_expected = {2'b00, exp_len_q} + (LSIZE+2)'(1);

    case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          g_d     = pick_idx;
          grant_d = pick_oh;
          state_d = ST_AW;
        end
      end
      ST_AW: begin
        if (sel_awvalid && m_awready) begin
          exp_len_d  = sel_awlen;
          beat_cnt_d = '0;
          state_d    = ST_W;
        end
      end
      ST_W: begin
        if (sel_wvalid && m_wready) begin
          beat_cnt_d = beat_inc;
          if (sel_wlast) begin
            state_d = ST_B;
            if (beats_seen != beats_expected) err_len_d = 1'b1;
          end
        end
      end
      ST_B: begin
        if (m_bvalid && sel_bready) begin
          rr_ptr_d = g_q;
          grant_d  = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel steering: only the owner sees ready/valid, and only in its phase.
  always_comb begin
    m_awvalid = (state_q == ST_AW) && sel_awvalid;
    m_awaddr  = sel_awaddr;
    m_awlen   = sel_awlen;
    m_awid    = {g_q, sel_awid};
    s_awready = (state_q == ST_AW && m_awready) ? grant_q : '0;

    m_wvalid  = (state_q == ST_W) && sel_wvalid;
    m_wlast   = (state_q == ST_W) && sel_wlast;
    m_wdata   = sel_wdata;
    s_wready  = (state_q == ST_W && m_wready) ? grant_q : '0;

    m_bready  = (state_q == ST_B) && sel_bready;
    s_bvalid  = (state_q == ST_B && m_bvalid) ? grant_q : '0;
    s_bid     = m_bid[IDSIZE-1:0];
    s_bresp   = m_bresp;

    grant     = grant_q;
    err_len   = err_len_q;
  end

endmodule

// File: tb/tb_axi4_wr_rr_arbiter.sv
// Bench for axi4_wr_rr_arbiter: randomized masters and slave, checked every
// cycle against a transaction-level model of ownership, rotation and length.

module tb_axi4_wr_rr_arbiter;

  localparam int NUM    = 4;
  localparam int IDSIZE = 4;
  localparam int ASIZE  = 32;
  localparam int LSIZE  = 8;
  localparam int DSIZE  = 32;

  logic axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  logic                  axi_aresetn;
  logic [NUM-1:0]        s_awvalid, s_awready;
  logic [NUM*ASIZE-1:0]  s_awaddr;
  logic [NUM*LSIZE-1:0]  s_awlen;
  logic [NUM*IDSIZE-1:0] s_awid;
  logic [NUM-1:0]        s_wvalid, s_wready, s_wlast;
  logic [NUM*DSIZE-1:0]  s_wdata;
  logic [NUM-1:0]        s_bvalid, s_bready;
  logic [IDSIZE-1:0]     s_bid;
  logic [1:0]            s_bresp;
  logic                  m_awvalid, m_awready;
  logic [ASIZE-1:0]      m_awaddr;
  logic [LSIZE-1:0]      m_awlen;
  logic [IDSIZE+2:0]     m_awid;
  logic                  m_wvalid, m_wready, m_wlast;
  logic [DSIZE-1:0]      m_wdata;
  logic                  m_bvalid, m_bready;
  logic [IDSIZE+2:0]     m_bid;
  logic [1:0]            m_bresp;
  logic [NUM-1:0]        grant;
  logic                  err_len;

  axi4_wr_rr_arbiter #(
    .NUM(NUM), .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE)
  ) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awid(m_awid),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .grant(grant), .err_len(err_len)
  );

  typedef struct {
    logic [ASIZE-1:0]  addr;
    logic [LSIZE-1:0]  len;
    logic [IDSIZE-1:0] id;
    int                nb;
  } txn_t;

  txn_t txq [NUM][$];
  txn_t cur [NUM];
  bit   act [NUM];
  bit   awdone [NUM];
  int   sent [NUM];

  // model: owner (-1 = idle), phase 0=AW 1=W 2=B, last winner, sticky error
  int owner, phase, ptr, bcnt, slave_beats;
  bit exp_err;
  int order[$];

  int p_wv, p_br, aw_mode, w_mode, bdelay;
  bit tog, rst_n;
  int n_checks, n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit roll(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  function automatic bit busy();
    bit b;
    b = (owner >= 0);
    for (int i = 0; i < NUM; i++) if (act[i] || txq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  function automatic txn_t mk(input int len, input int nb, input int id, input logic [31:0] addr);
    txn_t t;
    t.addr = addr;
    t.len  = LSIZE'(len);
    t.id   = IDSIZE'(id);
    t.nb   = nb;
    return t;
  endfunction

  task automatic cycle();
    logic [NUM-1:0] eg, eaw, ew, eb;
    int o;
    bit found;
    @(negedge axi_aclk);
    axi_aresetn = rst_n;
    tog = ~tog;
    for (int i = 0; i < NUM; i++)
      if (!act[i] && txq[i].size() > 0) begin
        cur[i] = txq[i].pop_front();
        act[i] = 1'b1; awdone[i] = 1'b0; sent[i] = 0;
      end
    for (int i = 0; i < NUM; i++) begin
      s_awvalid[i] = act[i] && !awdone[i];
      s_awaddr[i*ASIZE +: ASIZE]   = act[i] ? cur[i].addr : ASIZE'($urandom());
      s_awlen[i*LSIZE +: LSIZE]    = act[i] ? cur[i].len  : LSIZE'($urandom());
      s_awid[i*IDSIZE +: IDSIZE]   = act[i] ? cur[i].id   : IDSIZE'($urandom());
      if (act[i] && awdone[i]) begin
        s_wvalid[i] = (sent[i] < cur[i].nb) && roll(p_wv);
        s_wlast[i]  = (sent[i] + 1 == cur[i].nb);
      end else begin
        s_wvalid[i] = roll(30);
        s_wlast[i]  = roll(50);
      end
      s_wdata[i*DSIZE +: DSIZE] = DSIZE'($urandom());
      s_bready[i] = roll(p_br);
    end
    m_awready = (aw_mode == 0) ? 1'b1 : roll(50);
    m_wready  = (w_mode == 0) ? 1'b1 : (w_mode == 1) ? tog : roll(50);
    m_bvalid  = (owner >= 0) && (phase == 2) && (bcnt == 0);
    if (owner >= 0) m_bid = {3'(owner), cur[owner].id};
    else            m_bid = (IDSIZE+3)'($urandom());
    m_bresp = 2'($urandom());
    #1;
    o = owner;
    eg = '0; eaw = '0; ew = '0; eb = '0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      if (phase == 0 && m_awready) eaw[o] = 1'b1;
      if (phase == 1 && m_wready)  ew[o]  = 1'b1;
      if (phase == 2 && m_bvalid)  eb[o]  = 1'b1;
    end
    check_eq("grant", grant, eg);
    check_eq("s_awready", s_awready, eaw);
    check_eq("s_wready", s_wready, ew);
    check_eq("s_bvalid", s_bvalid, eb);
    check_eq("err_len", err_len, exp_err);
    check_eq("m_awvalid", m_awvalid, (o >= 0 && phase == 0) ? s_awvalid[o] : 1'b0);
    check_eq("m_wvalid", m_wvalid, (o >= 0 && phase == 1) ? s_wvalid[o] : 1'b0);
    check_eq("m_bready", m_bready, (o >= 0 && phase == 2) ? s_bready[o] : 1'b0);
    if (o >= 0 && phase == 0) begin
      check_eq("m_awaddr", m_awaddr, cur[o].addr);
      check_eq("m_awlen", m_awlen, cur[o].len);
      check_eq("m_awid", m_awid, {3'(o), cur[o].id});
    end
    if (o >= 0 && phase == 1 && m_wvalid) begin
      check_eq("m_wdata", m_wdata, s_wdata[o*DSIZE +: DSIZE]);
      check_eq("m_wlast", m_wlast, s_wlast[o]);
    end
    if (o >= 0 && phase == 2 && m_bvalid) begin
      check_eq("s_bid", s_bid, cur[o].id);
      check_eq("s_bresp", s_bresp, m_bresp);
    end
    if (rst_n) begin
      if (m_wvalid && m_wready) slave_beats++;
      if (o < 0) begin
        found = 1'b0;
        for (int k = 1; k <= NUM; k++) begin
          int c;
          c = (ptr + k) % NUM;
          if (!found && s_awvalid[c]) begin
            found = 1'b1; owner = c; phase = 0; order.push_back(c);
          end
        end
      end else if (phase == 0) begin
        if (s_awvalid[o] && m_awready) begin
          awdone[o] = 1'b1; phase = 1; slave_beats = 0;
        end
      end else if (phase == 1) begin
        if (s_wvalid[o] && m_wready) begin
          sent[o]++;
          if (s_wlast[o]) begin
            phase = 2;
            bcnt  = bdelay;
            if (sent[o] != int'(cur[o].len) + 1) exp_err = 1'b1;
            check_eq("beats_out", slave_beats, cur[o].nb);
          end
        end
      end else begin
        if (bcnt > 0) bcnt--;
        else if (s_bready[o]) begin
          act[o] = 1'b0; ptr = o; owner = -1;
        end
      end
    end else begin
      if (o >= 0 && awdone[o]) act[o] = 1'b0;
      owner = -1; phase = 0; ptr = NUM - 1; exp_err = 1'b0; bcnt = 0;
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (busy() && n < max_cycles) begin
      cycle();
      n++;
    end
    check_eq("drain_done", busy(), 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  task automatic easy_modes();
    p_wv = 100; p_br = 100; aw_mode = 0; w_mode = 0; bdelay = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_checks = 0; n_errors = 0;
    owner = -1; phase = 0; ptr = NUM - 1; bcnt = 0; slave_beats = 0; exp_err = 1'b0;
    tog = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < NUM; i++) begin act[i] = 1'b0; awdone[i] = 1'b0; sent[i] = 0; end
    axi_aresetn = 1'b0;
    s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_awid = '0;
    s_wvalid = '0; s_wlast = '0; s_wdata = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    easy_modes();
    repeat (2) @(posedge axi_aclk);

    // reset values, then single requester 2
    do_reset();
    order.delete();
    txq[2].push_back(mk(3, 4, 5, 32'h100));
    drain(200);
    check_eq("s1_count", order.size(), 1);
    check_eq("s1_owner", order[0], 2);

    // all four at once from reset, two rounds
    do_reset();
    order.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM; i++)
        txq[i].push_back(mk(i, i + 1, $urandom_range(15), $urandom()));
    drain(400);
    check_eq("s2_count", order.size(), 2 * NUM);
    for (int k = 0; k < 2 * NUM; k++) check_eq("s2_order", order[k], k % NUM);

    // backpressure: toggling wready, late B, sparse valids
    p_wv = 60; p_br = 50; aw_mode = 1; w_mode = 1; bdelay = 10;
    txq[1].push_back(mk(5, 6, 3, $urandom()));
    txq[3].push_back(mk(5, 6, 9, $urandom()));
    txq[0].push_back(mk(2, 3, 1, $urandom()));
    drain(1000);

    // length errors: early wlast, then clean, then late wlast
    easy_modes();
    txq[0].push_back(mk(3, 2, 7, $urandom()));
    drain(100);
    check_eq("s4_err_set", err_len, 1'b1);
    txq[2].push_back(mk(2, 3, 2, $urandom()));
    txq[1].push_back(mk(0, 1, 4, $urandom()));
    txq[3].push_back(mk(1, 4, 6, $urandom()));
    drain(200);
    check_eq("s4_err_sticky", err_len, 1'b1);

    // single beat on req 1, re-request while req 3 waits
    do_reset();
    order.delete();
    txq[1].push_back(mk(0, 1, 1, $urandom()));
    txq[1].push_back(mk(0, 1, 2, $urandom()));
    txq[3].push_back(mk(2, 3, 3, $urandom()));
    drain(200);
    check_eq("s5_count", order.size(), 3);
    check_eq("s5_first", order[0], 1);
    check_eq("s5_second", order[1], 3);
    check_eq("s5_third", order[2], 1);

    // random soak
    p_wv = 70; p_br = 70; aw_mode = 1; w_mode = 2; bdelay = $urandom_range(3);
    for (int t = 0; t < 30; t++) begin
      int len, nb, r;
      r   = $urandom_range(NUM - 1);
      len = $urandom_range(7);
      nb  = roll(80) ? len + 1 : $urandom_range(9, 1);
      txq[r].push_back(mk(len, nb, $urandom_range(15), $urandom()));
    end
    drain(5000);

    // reset during W beat 2 of 8
    easy_modes();
    do_reset();
    order.delete();
    txq[0].push_back(mk(7, 8, 5, $urandom()));
    txq[0].push_back(mk(0, 1, 6, $urandom()));
    for (int i = 1; i < NUM; i++) txq[i].push_back(mk(1, 2, i, $urandom()));
    n = 0;
    while (!(owner == 0 && phase == 1 && sent[0] == 1) && n < 100) begin
      cycle();
      n++;
    end
    check_eq("s7_reached_beat2", (owner == 0 && phase == 1 && sent[0] == 1), 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    order.delete();
    cycle();
    check_eq("s7_grant_after_rst", grant, '0);
    check_eq("s7_wvalid_after_rst", m_wvalid, 1'b0);
    drain(400);
    check_eq("s7_count", order.size(), NUM);
    for (int k = 0; k < NUM; k++) check_eq("s7_order", order[k], k);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
